// File: rtl/canxl_fcrc_ctrl_if.sv
// Bit-stream side and CRC-engine side signals of canxl_fcrc_ctrl.
// With FCRC_ERR_CNT_EN defined the interface also carries err_cnt.
interface canxl_fcrc_ctrl_if #(
  parameter int CRC_W = 32,
  parameter int CNT_W = 16
);
  logic             frm_start;
  logic             tx_mode;
  logic             abort;
  logic             bit_valid;
  logic             bit_in;
  logic             cov_last;
  logic [CRC_W-1:0] fcrc_frm;
  logic             fcrc_data;
  logic             fcrc_enable;
  logic             fcrc_init;
  logic             tx_bit;
  logic             busy;
  logic             crc_ok;
  logic             crc_err;
  logic             tx_done;
  logic [CNT_W-1:0] cov_cnt;
`ifdef FCRC_ERR_CNT_EN
  logic [7:0]       err_cnt;

  modport master (
    output frm_start, tx_mode, abort, bit_valid, bit_in, cov_last, fcrc_frm,
    input  fcrc_data, fcrc_enable, fcrc_init, tx_bit, busy, crc_ok, crc_err, tx_done, cov_cnt,
           err_cnt
  );
  modport slave (
    input  frm_start, tx_mode, abort, bit_valid, bit_in, cov_last, fcrc_frm,
    output fcrc_data, fcrc_enable, fcrc_init, tx_bit, busy, crc_ok, crc_err, tx_done, cov_cnt,
           err_cnt
  );
`else
  modport master (
    output frm_start, tx_mode, abort, bit_valid, bit_in, cov_last, fcrc_frm,
    input  fcrc_data, fcrc_enable, fcrc_init, tx_bit, busy, crc_ok, crc_err, tx_done, cov_cnt
  );
  modport slave (
    input  frm_start, tx_mode, abort, bit_valid, bit_in, cov_last, fcrc_frm,
    output fcrc_data, fcrc_enable, fcrc_init, tx_bit, busy, crc_ok, crc_err, tx_done, cov_cnt
  );
`endif
endinterface

// File: rtl/canxl_fcrc_ctrl.sv
// Sequencer for the CAN XL frame CRC engine: init, covered-bit gating, snapshot, TX serialise / RX compare.
// Define FCRC_ERR_CNT_EN to add the saturating RX CRC error counter err_cnt.
module canxl_fcrc_ctrl #(
  parameter int CRC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             g_rst,
  canxl_fcrc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_COVER    = 3'd2,
    S_SETTLE   = 3'd3,
    S_TX_SHIFT = 3'd4,
    S_RX_CMP   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [5:0] LAST_BIT = 6'(CRC_W - 1);

  state_t           state_q, state_d;
  logic [CRC_W-1:0] snap_q, snap_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cov_cnt_q, cov_cnt_d;
  logic             tx_mode_q, tx_mode_d;
  logic             mism_q, mism_d;
  logic             fcrc_init_q, fcrc_init_d;
  logic             tx_bit_q, tx_bit_d;
  logic             busy_q, busy_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_err_q, crc_err_d;
  logic             tx_done_q, tx_done_d;
`ifdef FCRC_ERR_CNT_EN
  logic [7:0]       err_cnt_q, err_cnt_d;
  assign bus.err_cnt = err_cnt_q;
`endif

  // The engine sees covered bits in the same cycle they arrive.
  assign bus.fcrc_data   = bus.bit_in;
  assign bus.fcrc_enable = bus.bit_valid & (state_q == S_COVER);
  assign bus.fcrc_init   = fcrc_init_q;
  assign bus.tx_bit      = tx_bit_q;
  assign bus.busy        = busy_q;
  assign bus.crc_ok      = crc_ok_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.cov_cnt     = cov_cnt_q;

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    bit_cnt_d   = bit_cnt_q;
    cov_cnt_d   = cov_cnt_q;
    tx_mode_d   = tx_mode_q;
    mism_d      = mism_q;
    fcrc_init_d = 1'b0;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    tx_done_d   = 1'b0;
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d     = S_IDLE;
      fcrc_init_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.frm_start) begin
            tx_mode_d   = bus.tx_mode;
            fcrc_init_d = 1'b1;
            state_d     = S_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_INIT: begin
          cov_cnt_d = '0;
          bit_cnt_d = 6'd0;
          mism_d    = 1'b0;
          state_d   = S_COVER;
        end
        S_COVER: begin
          if (bus.bit_valid) begin
            cov_cnt_d = (&cov_cnt_q) ? cov_cnt_q : cov_cnt_q + CNT_W'(1);
            state_d   = bus.cov_last ? S_SETTLE : S_COVER;
          end else begin
            state_d = S_COVER;
          end
        end
        S_SETTLE: begin
          snap_d  = bus.fcrc_frm;
          state_d = tx_mode_q ? S_TX_SHIFT : S_RX_CMP;
        end
        S_TX_SHIFT: begin
          if (bus.bit_valid) begin
            snap_d    = {snap_q[CRC_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
            tx_done_d = (bit_cnt_q == LAST_BIT);
            state_d   = (bit_cnt_q == LAST_BIT) ? S_IDLE : S_TX_SHIFT;
          end else begin
            state_d = S_TX_SHIFT;
          end
        end
        S_RX_CMP: begin
          if (bus.bit_valid) begin
            mism_d    = mism_q | (bus.bit_in ^ snap_q[CRC_W-1]);
            snap_d    = {snap_q[CRC_W-2:0], bus.bit_in};
            bit_cnt_d = bit_cnt_q + 6'd1;
            // Verdict is registered on the way into DONE so it is visible during DONE.
            crc_ok_d  = (bit_cnt_q == LAST_BIT) & ~mism_d;
            crc_err_d = (bit_cnt_q == LAST_BIT) & mism_d;
            state_d   = (bit_cnt_q == LAST_BIT) ? S_DONE : S_RX_CMP;
          end else begin
            state_d = S_RX_CMP;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    tx_bit_d = (state_d == S_TX_SHIFT) ? snap_d[CRC_W-1] : 1'b0;
    busy_d   = (state_d != S_IDLE);
`ifdef FCRC_ERR_CNT_EN
    err_cnt_d = (crc_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_q     <= S_IDLE;
      snap_q      <= '0;
      bit_cnt_q   <= 6'd0;
      cov_cnt_q   <= '0;
      tx_mode_q   <= 1'b0;
      mism_q      <= 1'b0;
      fcrc_init_q <= 1'b0;
      tx_bit_q    <= 1'b0;
      busy_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef FCRC_ERR_CNT_EN
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      bit_cnt_q   <= bit_cnt_d;
      cov_cnt_q   <= cov_cnt_d;
      tx_mode_q   <= tx_mode_d;
      mism_q      <= mism_d;
      fcrc_init_q <= fcrc_init_d;
      tx_bit_q    <= tx_bit_d;
      busy_q      <= busy_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      tx_done_q   <= tx_done_d;
`ifdef FCRC_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_canxl_fcrc_ctrl.sv
// Bench for canxl_fcrc_ctrl: serial CRC engine stand-in, polynomial-division reference, directed + random frames.
// Define FCRC_ERR_CNT_EN to also exercise err_cnt.
module tb_canxl_fcrc_ctrl;
  localparam int          CRC_W = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'hFA567D89;

  logic clk   = 1'b0;
  logic g_rst = 1'b1;
  always #5 clk = ~clk;

  canxl_fcrc_ctrl_if #(.CRC_W(CRC_W), .CNT_W(CNT_W)) bus ();
  canxl_fcrc_ctrl #(.CRC_W(CRC_W), .CNT_W(CNT_W)) dut (.clk(clk), .g_rst(g_rst), .bus(bus));

  // Stand-in CRC engine: MSB-first serial register, zero seed.
  logic [31:0] eng_q;
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) eng_q <= 32'd0;
    else if (bus.fcrc_init) eng_q <= 32'd0;
    else if (bus.fcrc_enable)
      eng_q <= (eng_q[31] ^ bus.fcrc_data) ? ({eng_q[30:0], 1'b0} ^ POLY) : {eng_q[30:0], 1'b0};
  end
  assign bus.fcrc_frm = eng_q;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  bit cov_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The engine must never be told to init and update in the same cycle.
  always @(negedge clk) begin
    if (!g_rst) begin
      n_assert++;
      assert (!(bus.fcrc_init && bus.fcrc_enable)) else begin
        n_fail++;
        $error("FAIL init_enable_overlap: observed 1 expected 0");
      end
    end
  end

  // Reference: remainder of msg * x^32 divided by the generator polynomial.
  function automatic logic [31:0] crc_of(input bit msg[$]);
    bit m[$];
    logic [32:0] p;
    logic [31:0] r;
    m = msg;
    for (int k = 0; k < 32; k++) m.push_back(1'b0);
    p = {1'b1, POLY};
    for (int i = 0; i + 32 < m.size(); i++)
      if (m[i]) for (int j = 0; j < 33; j++) m[i+j] = m[i+j] ^ p[32-j];
    r = 32'd0;
    for (int k = 0; k < 32; k++) r[31-k] = m[m.size()-32+k];
    return r;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic tx);
    bus.frm_start = 1'b1; bus.tx_mode = tx; bus.bit_valid = 1'b0; bus.cov_last = 1'b0;
    step();
    chk("init_pulse", 32'(bus.fcrc_init), 32'd1);
    chk("busy_start", 32'(bus.busy), 32'd1);
    bus.frm_start = 1'b0; bus.tx_mode = rbit();
    bus.bit_valid = rbit(); bus.bit_in = rbit(); bus.cov_last = rbit();
    #1 chk("en_in_init", 32'(bus.fcrc_enable), 32'd0);
    step();
    chk("init_drop", 32'(bus.fcrc_init), 32'd0);
    chk("cov_clear", 32'(bus.cov_cnt), 32'd0);
    bus.bit_valid = 1'b0; bus.cov_last = 1'b0;
  endtask

  task automatic cover_frame(input bit last_flag);
    for (int i = 0; i < cov_q.size(); i++) begin
      if ($urandom_range(3, 0) == 0) begin
        bus.bit_valid = 1'b0; bus.cov_last = 1'b1; bus.bit_in = rbit();
        step();
        chk("cov_idle", 32'(bus.cov_cnt), 32'(i));
        bus.cov_last = 1'b0;
      end
      bus.bit_valid = 1'b1; bus.bit_in = cov_q[i];
      bus.cov_last  = last_flag && (i == cov_q.size() - 1);
      bus.frm_start = ($urandom_range(7, 0) == 0);
      #1;
      chk("en_cover", 32'(bus.fcrc_enable), 32'd1);
      chk("data_cover", 32'(bus.fcrc_data), 32'(cov_q[i]));
      step();
      chk("cov_cnt", 32'(bus.cov_cnt), 32'(i + 1));
      chk("no_reinit", 32'(bus.fcrc_init), 32'd0);
      bus.frm_start = 1'b0;
    end
    bus.bit_valid = 1'b0; bus.cov_last = 1'b0;
  endtask

  task automatic settle();
    bus.bit_valid = rbit(); bus.bit_in = rbit();
    #1 chk("en_settle", 32'(bus.fcrc_enable), 32'd0);
    step();
    bus.bit_valid = 1'b0;
    chk("cov_final", 32'(bus.cov_cnt), 32'(cov_q.size()));
  endtask

  task automatic tx_bits(input logic [31:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3, 0) == 0) begin bus.bit_valid = 1'b0; step(); end
      chk("tx_bit", 32'(bus.tx_bit), 32'(exp[31-i]));
      chk("tx_done_early", 32'(bus.tx_done), 32'd0);
      chk("busy_tx", 32'(bus.busy), 32'd1);
      bus.bit_valid = 1'b1; bus.bit_in = rbit();
      step();
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic rx_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3, 0) == 0) begin bus.bit_valid = 1'b0; step(); end
      chk("rx_no_ok", 32'(bus.crc_ok), 32'd0);
      chk("rx_no_err", 32'(bus.crc_err), 32'd0);
      bus.bit_valid = 1'b1; bus.bit_in = v[31-i];
      step();
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic run_frame(input logic tx, input logic [31:0] exp, input logic [31:0] rx_val);
    start_frame(tx);
    cover_frame(1'b1);
    settle();
    if (tx) begin
      tx_bits(exp, 32);
      chk("tx_done", 32'(bus.tx_done), 32'd1);
      chk("busy_tx_end", 32'(bus.busy), 32'd0);
      chk("tx_no_ok", 32'(bus.crc_ok), 32'd0);
      chk("tx_no_err", 32'(bus.crc_err), 32'd0);
      step();
      chk("tx_done_pulse", 32'(bus.tx_done), 32'd0);
    end else begin
      rx_bits(rx_val, 32);
      bus.bit_valid = rbit(); bus.bit_in = rbit();
      chk("crc_ok", 32'(bus.crc_ok), 32'(rx_val == exp));
      chk("crc_err", 32'(bus.crc_err), 32'(rx_val != exp));
      chk("busy_done", 32'(bus.busy), 32'd1);
`ifdef FCRC_ERR_CNT_EN
      if (rx_val != exp && exp_err < 255) exp_err++;
      chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err));
`endif
      step();
      bus.bit_valid = 1'b0;
      chk("ok_pulse", 32'(bus.crc_ok), 32'd0);
      chk("err_pulse", 32'(bus.crc_err), 32'd0);
      chk("busy_rx_end", 32'(bus.busy), 32'd0);
      chk("no_tx_done", 32'(bus.tx_done), 32'd0);
    end
  endtask

  task automatic abort_check(input string tag);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0; bus.bit_valid = 1'b0;
    chk({tag, "_init"}, 32'(bus.fcrc_init), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ok"}, 32'(bus.crc_ok), 32'd0);
    chk({tag, "_err"}, 32'(bus.crc_err), 32'd0);
    chk({tag, "_done"}, 32'(bus.tx_done), 32'd0);
    step();
    chk({tag, "_init_drop"}, 32'(bus.fcrc_init), 32'd0);
    chk({tag, "_ok2"}, 32'(bus.crc_ok), 32'd0);
    chk({tag, "_err2"}, 32'(bus.crc_err), 32'd0);
    chk({tag, "_done2"}, 32'(bus.tx_done), 32'd0);
  endtask

  task automatic rand_cov(input int n);
    cov_q.delete();
    for (int i = 0; i < n; i++) cov_q.push_back(rbit());
  endtask

  initial begin
    logic        tx;
    logic [31:0] exp, rx;
    bus.frm_start = 1'b0; bus.tx_mode = 1'b0; bus.abort = 1'b0;
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.cov_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init", 32'(bus.fcrc_init), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ok", 32'(bus.crc_ok), 32'd0);
    chk("rst_err", 32'(bus.crc_err), 32'd0);
    chk("rst_done", 32'(bus.tx_done), 32'd0);
    chk("rst_tx_bit", 32'(bus.tx_bit), 32'd0);
    chk("rst_cov_cnt", 32'(bus.cov_cnt), 32'd0);
`ifdef FCRC_ERR_CNT_EN
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    g_rst = 1'b0;
    step();

    // Directed frames from a single covered '1'.
    cov_q.delete(); cov_q.push_back(1'b1);
    run_frame(1'b0, 32'hFA567D89, 32'hFA567D89);
    run_frame(1'b0, 32'hFA567D89, 32'hFA567D88);
    run_frame(1'b1, 32'hFA567D89, 32'd0);

    // Random frames against the division reference.
    repeat (30) begin
      rand_cov($urandom_range(40, 1));
      tx  = rbit();
      exp = crc_of(cov_q);
      rx  = exp;
      if (rbit()) rx = rx ^ (32'd1 << $urandom_range(31, 0));
      run_frame(tx, exp, rx);
    end

    // Abort after 5 covered bits.
    rand_cov(5);
    start_frame(1'b0);
    cover_frame(1'b0);
    chk("abort_cov5", 32'(bus.cov_cnt), 32'd5);
    abort_check("abort_cover");

    // Abort midway through TX serialisation.
    rand_cov($urandom_range(20, 1));
    exp = crc_of(cov_q);
    start_frame(1'b1);
    cover_frame(1'b1);
    settle();
    tx_bits(exp, 10);
    abort_check("abort_tx");

    // Abort on the final, mismatching RX bit: no verdict.
    rand_cov($urandom_range(20, 1));
    rx = ~crc_of(cov_q);
    start_frame(1'b0);
    cover_frame(1'b1);
    settle();
    rx_bits(rx, 31);
    bus.bit_valid = 1'b1; bus.bit_in = rx[0];
    abort_check("abort_rx");

    // Recovery after aborts.
    rand_cov($urandom_range(30, 1));
    exp = crc_of(cov_q);
    run_frame(1'b0, exp, exp);
    run_frame(1'b1, exp, 32'd0);

`ifdef FCRC_ERR_CNT_EN
    cov_q.delete(); cov_q.push_back(1'b1);
    repeat (256) run_frame(1'b0, 32'hFA567D89, 32'h0000_0000);
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
